// File: rtl/mips_core_pkg.sv
// rtl/mips_core_pkg.sv - shared fetch/decode types for the mips core
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;

    // One fetched instruction with its PC, passed from fetch to decode.
    typedef struct packed {
        logic [31:0]           data;
        logic [ADDR_WIDTH-1:0] pc;
    } inst_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// rtl/inst_queue_if.sv - fetch-side and decode-side handshake of the instruction queue
interface inst_queue_if;
    import mips_core_pkg::*;

    logic                  i_valid;
    logic [31:0]           i_data;
    logic [ADDR_WIDTH-1:0] i_pc;
    logic                  o_ready;

    logic                  o_valid;
    logic [31:0]           o_data;
    logic [ADDR_WIDTH-1:0] o_pc;
    logic                  i_ready;

    // The queue is the slave; fetch/decode (or a bench) drive as master.
    modport slave (
        input  i_valid, i_data, i_pc, i_ready,
        output o_ready, o_valid, o_data, o_pc
    );

    modport master (
        output i_valid, i_data, i_pc, i_ready,
        input  o_ready, o_valid, o_data, o_pc
    );

endinterface

// File: rtl/inst_queue_storage.sv
// rtl/inst_queue_storage.sv - entry array with synchronous write and asynchronous read
module inst_queue_storage
    import mips_core_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  inst_entry_t       wdata,
    input  logic [PTR_W-1:0]  raddr,
    output inst_entry_t       rdata
);

    // Contents are intentionally not reset; validity is tracked by the pointers.
    inst_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - show-ahead circular FIFO between instruction fetch and decode
module inst_queue
    import mips_core_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    inst_queue_if.slave      q,
    input  logic             i_flush,
    output logic [PTR_W:0]   o_count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;
    inst_entry_t      wr_entry;
    inst_entry_t      rd_entry;

    // Flow control comes only from registered occupancy, never from i_ready.
    assign q.o_ready = (count != FULL_CNT);
    assign q.o_valid = (count != '0);

    assign push = q.i_valid & q.o_ready & ~i_flush;
    assign pop  = q.o_valid & q.i_ready & ~i_flush;

    assign wr_entry.data = q.i_data;
    assign wr_entry.pc   = q.i_pc;

    inst_queue_storage #(.DEPTH(DEPTH)) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (rd_entry)
    );

    // Stale storage is masked so an empty queue presents zeros.
    assign q.o_data = q.o_valid ? rd_entry.data : '0;
    assign q.o_pc   = q.o_valid ? rd_entry.pc   : '0;
    assign o_count  = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_ONE;
            end
            if (pop) begin
                head <= head + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - directed self-checking bench for inst_queue
module tb_inst_queue;
    import mips_core_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       i_flush;
    logic [2:0] o_count;
    int         errors;
    int         checks;

    inst_queue_if qif();

    inst_queue #(.DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .q       (qif),
        .i_flush (i_flush),
        .o_count (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        qif.i_valid = 1'b0;
        qif.i_ready = 1'b0;
        qif.i_pc    = '0;
        qif.i_data  = '0;
        i_flush     = 1'b0;
    endtask

    task automatic push_no_pop(input logic [31:0] pc);
        qif.i_valid = 1'b1;
        qif.i_ready = 1'b0;
        qif.i_pc    = pc;
        qif.i_data  = word_of(pc);
        cyc();
        qif.i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #3;
        checks++;
        if (qif.o_valid !== 1'b0 || qif.o_ready !== 1'b1 || o_count !== 3'd0 ||
            qif.o_data !== 32'd0 || qif.o_pc !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: valid=%b ready=%b count=%0d data=%h pc=%h, want 0 1 0 0 0",
                     qif.o_valid, qif.o_ready, o_count, qif.o_data, qif.o_pc);
        end
        cyc();
        rst_n = 1'b1;
        qif.i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if (qif.o_valid !== 1'b0 || o_count !== 3'd0 || qif.o_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_after_reset[%0d]: valid=%b count=%0d ready=%b, want 0 0 1",
                         k, qif.o_valid, o_count, qif.o_ready);
            end
        end
        qif.i_ready = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int k = 0; k < 4; k++) push_no_pop(32'h100 + 32'(4 * k));
        checks++;
        if (o_count !== 3'd4 || qif.o_ready !== 1'b0 || qif.o_pc !== 32'h100 || qif.o_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_full: count=%0d ready=%b pc=%h valid=%b, want 4 0 00000100 1",
                     o_count, qif.o_ready, qif.o_pc, qif.o_valid);
        end
        push_no_pop(32'h110);
        checks++;
        if (o_count !== 3'd4 || qif.o_pc !== 32'h100) begin
            errors++;
            $display("FAIL fifth_push_refused: count=%0d pc=%h, want 4 00000100", o_count, qif.o_pc);
        end
        qif.i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (qif.o_pc !== 32'h100 + 32'(4 * k) || qif.o_data !== word_of(32'h100 + 32'(4 * k))) begin
                errors++;
                $display("FAIL drain_order[%0d]: pc=%h data=%h, want %h %h", k, qif.o_pc, qif.o_data,
                         32'h100 + 32'(4 * k), word_of(32'h100 + 32'(4 * k)));
            end
            cyc();
        end
        checks++;
        if (qif.o_valid !== 1'b0 || o_count !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: valid=%b count=%0d, want 0 0", qif.o_valid, o_count);
        end
        qif.i_ready = 1'b0;
    endtask

    task automatic test_stream();
        qif.i_valid = 1'b1;
        qif.i_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            qif.i_pc   = 32'h200 + 32'(4 * k);
            qif.i_data = word_of(qif.i_pc);
            if (k > 0) begin
                checks++;
                if (o_count !== 3'd1 || qif.o_pc !== 32'h200 + 32'(4 * (k - 1)) ||
                    qif.o_data !== word_of(32'h200 + 32'(4 * (k - 1)))) begin
                    errors++;
                    $display("FAIL stream[%0d]: count=%0d pc=%h, want 1 %h", k, o_count, qif.o_pc,
                             32'h200 + 32'(4 * (k - 1)));
                end
            end
            cyc();
        end
        qif.i_valid = 1'b0;
        checks++;
        if (qif.o_pc !== 32'h24C || o_count !== 3'd1) begin
            errors++;
            $display("FAIL stream_last: pc=%h count=%0d, want 0000024c 1", qif.o_pc, o_count);
        end
        cyc();
        checks++;
        if (qif.o_valid !== 1'b0 || o_count !== 3'd0) begin
            errors++;
            $display("FAIL stream_drained: valid=%b count=%0d, want 0 0", qif.o_valid, o_count);
        end
        qif.i_ready = 1'b0;
    endtask

    task automatic test_full_pop();
        for (int k = 0; k < 4; k++) push_no_pop(32'h300 + 32'(4 * k));
        qif.i_valid = 1'b1;
        qif.i_ready = 1'b1;
        qif.i_pc    = 32'h310;
        qif.i_data  = word_of(32'h310);
        cyc();
        checks++;
        if (o_count !== 3'd3 || qif.o_pc !== 32'h304 || qif.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_refuses_push: count=%0d pc=%h ready=%b, want 3 00000304 1",
                     o_count, qif.o_pc, qif.o_ready);
        end
        qif.i_ready = 1'b0;
        cyc();
        qif.i_valid = 1'b0;
        checks++;
        if (o_count !== 3'd4) begin
            errors++;
            $display("FAIL full_retry_push: count=%0d, want 4", o_count);
        end
        qif.i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (qif.o_pc !== 32'h304 + 32'(4 * k)) begin
                errors++;
                $display("FAIL full_pop_order[%0d]: pc=%h, want %h", k, qif.o_pc, 32'h304 + 32'(4 * k));
            end
            cyc();
        end
        qif.i_ready = 1'b0;
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) push_no_pop(32'h500 + 32'(4 * k));
        i_flush     = 1'b1;
        qif.i_valid = 1'b1;
        qif.i_ready = 1'b1;
        qif.i_pc    = 32'h50C;
        qif.i_data  = word_of(32'h50C);
        cyc();
        idle_inputs();
        checks++;
        if (o_count !== 3'd0 || qif.o_valid !== 1'b0 || qif.o_data !== 32'd0) begin
            errors++;
            $display("FAIL flush_clears: count=%0d valid=%b data=%h, want 0 0 0", o_count, qif.o_valid, qif.o_data);
        end
        push_no_pop(32'h400);
        checks++;
        if (o_count !== 3'd1 || qif.o_pc !== 32'h400 || qif.o_data !== word_of(32'h400)) begin
            errors++;
            $display("FAIL flush_next_push: count=%0d pc=%h, want 1 00000400", o_count, qif.o_pc);
        end
        qif.i_ready = 1'b1;
        cyc();
        qif.i_ready = 1'b0;
        i_flush = 1'b1;
        cyc();
        i_flush = 1'b0;
        checks++;
        if (o_count !== 3'd0 || qif.o_ready !== 1'b1 || qif.o_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: count=%0d ready=%b valid=%b, want 0 1 0", o_count, qif.o_ready, qif.o_valid);
        end
    endtask

    task automatic test_reset_mid();
        push_no_pop(32'h600);
        push_no_pop(32'h604);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_count !== 3'd0 || qif.o_valid !== 1'b0 || qif.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_async: count=%0d valid=%b ready=%b, want 0 0 1",
                     o_count, qif.o_valid, qif.o_ready);
        end
        cyc();
        rst_n = 1'b1;
        push_no_pop(32'h700);
        checks++;
        if (o_count !== 3'd1 || qif.o_pc !== 32'h700 || qif.o_data !== word_of(32'h700)) begin
            errors++;
            $display("FAIL reset_mid_repush: count=%0d pc=%h data=%h, want 1 00000700 %h",
                     o_count, qif.o_pc, qif.o_data, word_of(32'h700));
        end
        qif.i_ready = 1'b1;
        cyc();
        qif.i_ready = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_fill_drain();
        test_stream();
        test_full_pop();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
